// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: buffers DIGITS active-low patterns and scans them onto one bus.
// Optional macro SEG_GHOST_BLANK_EN blanks the first two cycles of every digit slot (dead time).
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int IDX_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_in,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  output logic [6:0]        seg_out,
  output logic [DIGITS-1:0] an_out,
  output logic              frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(DIGITS - 1);
  localparam logic [IDX_W:0]    DIGITS_EXT = (IDX_W + 1)'(DIGITS);
  localparam logic [DIGITS-1:0] AN_ONE     = DIGITS'(1);

  logic [6:0]       seg_buf [DIGITS];
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] ptr;

  logic             slot_end;
  logic             frame_end;
  logic             idx_ok;
  logic [PTR_W-1:0] wr_ptr;
  logic             blank;

  // wr_en is a fire-and-forget strobe (no ready): every cycle it is high with an
  // in-range index the pattern is captured; out-of-range indices are discarded.
  assign idx_ok    = ({1'b0, wr_idx} < DIGITS_EXT);
  assign wr_ptr    = PTR_W'(wr_idx);
  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (ptr == PTR_LAST);

`ifdef SEG_GHOST_BLANK_EN
  assign blank = (cnt < CNT_W'(2));
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        seg_buf[i] <= 7'b1111111;
      end
      cnt        <= '0;
      ptr        <= '0;
      seg_out    <= 7'b1111111;
      an_out     <= '1;
      frame_tick <= 1'b0;
    end else begin
      if (wr_en && idx_ok) begin
        seg_buf[wr_ptr] <= seg_in;
      end

      if (slot_end) begin
        cnt <= '0;
        ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      frame_tick <= frame_end;

      // Outputs reflect the pre-edge pointer and buffer, hence the one-cycle lag.
      if (blank) begin
        seg_out <= 7'b1111111;
        an_out  <= '1;
      end else begin
        seg_out <= seg_buf[ptr];
        an_out  <= ~(AN_ONE << ptr);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit and a 3-digit instance share stimulus and are
// checked against a cycle-index reference model.
module tb_seg7_scan_driver;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = 2'd0;
  logic [6:0] seg_in = 7'b1111111;

  logic [6:0] seg4, seg3;
  logic [3:0] an4;
  logic [2:0] an3;
  logic       ft4, ft3;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int unsigned k;
  logic [6:0]  mb4 [4];
  logic [6:0]  mb3 [3];
  logic [6:0]  exp_seg4, exp_seg3;
  logic [3:0]  exp_an4;
  logic [2:0]  exp_an3;
  logic        exp_ft4, exp_ft3;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(SD), .IDX_W(2)) u_dut4 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .wr_en(wr_en), .wr_idx(wr_idx),
    .seg_out(seg4), .an_out(an4), .frame_tick(ft4)
  );

  seg7_scan_driver #(.DIGITS(3), .SCAN_DIV(SD), .IDX_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .wr_en(wr_en), .wr_idx(wr_idx),
    .seg_out(seg3), .an_out(an3), .frame_tick(ft3)
  );

  // k counts edges since reset released; edge k displays slot (k-1)/SD, sub-cycle (k-1)%SD.
  task automatic model_step(input logic r, input logic we, input logic [1:0] idx,
                            input logic [6:0] d);
    int unsigned slot, c;
    if (r) begin
      k = 0;
      for (int i = 0; i < 4; i++) mb4[i] = 7'b1111111;
      for (int i = 0; i < 3; i++) mb3[i] = 7'b1111111;
      exp_seg4 = 7'b1111111; exp_an4 = 4'b1111; exp_ft4 = 1'b0;
      exp_seg3 = 7'b1111111; exp_an3 = 3'b111;  exp_ft3 = 1'b0;
    end else begin
      k = k + 1;
      slot = (k - 1) / SD;
      c    = (k - 1) % SD;
      exp_an4 = 4'b1111; exp_an4[slot % 4] = 1'b0; exp_seg4 = mb4[slot % 4];
      exp_an3 = 3'b111;  exp_an3[slot % 3] = 1'b0; exp_seg3 = mb3[slot % 3];
      exp_ft4 = ((k % (4 * SD)) == 0);
      exp_ft3 = ((k % (3 * SD)) == 0);
`ifdef SEG_GHOST_BLANK_EN
      if (c < 2) begin
        exp_an4 = 4'b1111; exp_seg4 = 7'b1111111;
        exp_an3 = 3'b111;  exp_seg3 = 7'b1111111;
      end
`endif
      if (we) begin
        mb4[idx] = d;
        if (idx < 3) mb3[idx] = d;
      end
    end
  endtask

  task automatic tick(input logic r, input logic we, input logic [1:0] idx,
                      input logic [6:0] d);
    rst = r; wr_en = we; wr_idx = idx; seg_in = d;
    @(posedge clk);
    model_step(r, we, idx, d);
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) begin
      tick(1'b1, 1'b1, 2'd0, 7'b0000000);
      n_checks++;
      if (seg4 !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg4 got=%b want=%b", seg4, 7'b1111111); end
      n_checks++;
      if (an4 !== 4'b1111) begin n_fail++; $display("FAIL reset_an4 got=%b want=%b", an4, 4'b1111); end
      n_checks++;
      if (ft4 !== 1'b0) begin n_fail++; $display("FAIL reset_ft4 got=%b want=0", ft4); end
      n_checks++;
      if (an3 !== 3'b111) begin n_fail++; $display("FAIL reset_an3 got=%b want=%b", an3, 3'b111); end
    end
    tick(1'b0, 1'b0, 2'd0, 7'b1111111);
    n_checks++;
`ifdef SEG_GHOST_BLANK_EN
    if (an4 !== 4'b1111) begin n_fail++; $display("FAIL release_an4 got=%b want=%b", an4, 4'b1111); end
`else
    if (an4 !== 4'b1110) begin n_fail++; $display("FAIL release_an4 got=%b want=%b", an4, 4'b1110); end
`endif
    n_checks++;
    if (seg4 !== 7'b1111111) begin n_fail++; $display("FAIL release_seg4 got=%b want=%b", seg4, 7'b1111111); end
  endtask

  task automatic test_scan;
    logic [6:0] pat [4];
    logic [6:0] seen [4];
    int ft_cnt;
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100; pat[3] = 7'b0000000;
    for (int i = 0; i < 4; i++) seen[i] = 7'bxxxxxxx;
    repeat (2) tick(1'b1, 1'b0, 2'd0, 7'b1111111);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 2'(i), pat[i]);
    ft_cnt = 0;
    for (int n = 0; n < 64; n++) begin
      tick(1'b0, 1'b0, 2'd0, 7'b1111111);
      n_checks++;
      if (seg4 !== exp_seg4 || an4 !== exp_an4 || ft4 !== exp_ft4) begin
        n_fail++;
        $display("FAIL scan k=%0d got seg=%b an=%b ft=%b want seg=%b an=%b ft=%b",
                 k, seg4, an4, ft4, exp_seg4, exp_an4, exp_ft4);
      end
      if (ft4) ft_cnt++;
      for (int d = 0; d < 4; d++) if (an4 == ~(4'b0001 << d)) seen[d] = seg4;
    end
    n_checks++;
    if (ft_cnt != 4) begin n_fail++; $display("FAIL scan_frame_count got=%0d want=4", ft_cnt); end
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (seen[d] !== pat[d]) begin n_fail++; $display("FAIL scan_digit%0d got=%b want=%b", d, seen[d], pat[d]); end
    end
  endtask

  task automatic test_live_update;
    repeat (2) tick(1'b1, 1'b0, 2'd0, 7'b1111111);
    repeat (5) tick(1'b0, 1'b0, 2'd0, 7'b1111111);
    tick(1'b0, 1'b1, 2'd1, 7'b0001000);
    tick(1'b0, 1'b0, 2'd0, 7'b1111111);
    n_checks++;
    if (an4 !== 4'b1101) begin n_fail++; $display("FAIL live_an4 got=%b want=%b", an4, 4'b1101); end
    n_checks++;
    if (seg4 !== 7'b0001000) begin n_fail++; $display("FAIL live_seg4 got=%b want=%b", seg4, 7'b0001000); end
    repeat (16) begin
      tick(1'b0, 1'b0, 2'd0, 7'b1111111);
      n_checks++;
      if (seg4 !== exp_seg4 || an4 !== exp_an4) begin
        n_fail++;
        $display("FAIL live_follow k=%0d got seg=%b an=%b want seg=%b an=%b", k, seg4, an4, exp_seg4, exp_an4);
      end
    end
  endtask

  task automatic test_out_of_range;
    int ft_cnt;
    repeat (2) tick(1'b1, 1'b0, 2'd0, 7'b1111111);
    tick(1'b0, 1'b1, 2'd3, 7'b1000110);
    ft_cnt = 0;
    repeat (36) begin
      tick(1'b0, 1'b0, 2'd0, 7'b1111111);
      n_checks++;
      if (seg3 !== 7'b1111111 || an3 !== exp_an3 || ft3 !== exp_ft3) begin
        n_fail++;
        $display("FAIL oor k=%0d got seg=%b an=%b ft=%b want seg=%b an=%b ft=%b",
                 k, seg3, an3, ft3, 7'b1111111, exp_an3, exp_ft3);
      end
      if (ft3) ft_cnt++;
    end
    n_checks++;
    if (ft_cnt != 3) begin n_fail++; $display("FAIL oor_frame_count got=%0d want=3", ft_cnt); end
  endtask

  task automatic test_mid_reset;
    repeat (2) tick(1'b1, 1'b0, 2'd0, 7'b1111111);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 2'(i), 7'(7'b0010010 + i));
    repeat (7) tick(1'b0, 1'b0, 2'd0, 7'b1111111);
    n_checks++;
    if (an4 !== 4'b1011) begin n_fail++; $display("FAIL midrst_pre_an4 got=%b want=%b", an4, 4'b1011); end
    tick(1'b1, 1'b1, 2'd0, 7'b0000000);
    n_checks++;
    if (seg4 !== 7'b1111111 || an4 !== 4'b1111) begin
      n_fail++; $display("FAIL midrst_rst got seg=%b an=%b want seg=%b an=%b", seg4, an4, 7'b1111111, 4'b1111);
    end
    tick(1'b0, 1'b0, 2'd0, 7'b1111111);
    n_checks++;
`ifdef SEG_GHOST_BLANK_EN
    if (an4 !== 4'b1111 || seg4 !== 7'b1111111) begin
      n_fail++; $display("FAIL midrst_release got seg=%b an=%b want seg=%b an=%b", seg4, an4, 7'b1111111, 4'b1111);
    end
`else
    if (an4 !== 4'b1110 || seg4 !== 7'b1111111) begin
      n_fail++; $display("FAIL midrst_release got seg=%b an=%b want seg=%b an=%b", seg4, an4, 7'b1111111, 4'b1110);
    end
`endif
    repeat (16) begin
      tick(1'b0, 1'b0, 2'd0, 7'b1111111);
      n_checks++;
      if (seg4 !== 7'b1111111) begin n_fail++; $display("FAIL midrst_lost k=%0d got=%b want=%b", k, seg4, 7'b1111111); end
    end
  endtask

  task automatic test_random;
    logic r, we;
    logic [1:0] idx;
    logic [6:0] d;
    repeat (2) tick(1'b1, 1'b0, 2'd0, 7'b1111111);
    repeat (400) begin
      r   = ($urandom_range(0, 39) == 0);
      we  = 1'($urandom_range(0, 1));
      idx = 2'($urandom_range(0, 3));
      d   = 7'($urandom);
      tick(r, we, idx, d);
      n_checks++;
      if (seg4 !== exp_seg4 || an4 !== exp_an4 || ft4 !== exp_ft4) begin
        n_fail++;
        $display("FAIL rand4 k=%0d got seg=%b an=%b ft=%b want seg=%b an=%b ft=%b",
                 k, seg4, an4, ft4, exp_seg4, exp_an4, exp_ft4);
      end
      n_checks++;
      if (seg3 !== exp_seg3 || an3 !== exp_an3 || ft3 !== exp_ft3) begin
        n_fail++;
        $display("FAIL rand3 k=%0d got seg=%b an=%b ft=%b want seg=%b an=%b ft=%b",
                 k, seg3, an3, ft3, exp_seg3, exp_an3, exp_ft3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_live_update();
    test_out_of_range();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
